// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, byte width
// and a one-hot to index helper used for pointer and header arithmetic.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TAG       = 3'd1,
        ST_SEND      = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_e;

    // Highest set bit wins; callers only ever pass one-hot or zero vectors.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: returns the first request at or after
// ptr_i (wrapping) as a one-hot vector, zero when nothing is requesting.
module uart_tx_arbiter_rr #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    int idx;

    // Scan farthest-first so the candidate closest to the pointer overwrites the rest.
    always_comb begin
        gnt_o = '0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART transmit core among N_REQ
// byte streams. Define UART_TX_ARB_TAG_EN to prefix each packet with TAG_BASE+owner.
import uart_tx_arbiter_pkg::*;

module uart_tx_arbiter #(
    parameter int          N_REQ    = 4,
    parameter int          GAP_CYC  = 4096,
    parameter logic [7:0]  TAG_BASE = 8'hA0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_dat_en,
    output logic [BYTE_W-1:0]         tx_din,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [N_REQ-1:0]          grant,
    output logic                      pkt_done,
    output logic                      gap_abort
);

    localparam int             GAP_W   = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_CYC - 1);

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [BYTE_W-1:0]   din_q, din_d;
    logic                dat_en_q, dat_en_d;
    logic                last_q, last_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                pkt_done_q, pkt_done_d;
    logic                gap_abort_q, gap_abort_d;

    logic [N_REQ-1:0]    win;
    logic [2:0]          g_idx;
    logic [2:0]          ptr_next;
    logic                g_valid;
    logic                g_last;
    logic [BYTE_W-1:0]   g_data;

    uart_tx_arbiter_rr #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (win)
    );

    always_comb begin
        g_idx    = onehot_idx(8'(grant_q));
        ptr_next = (int'(g_idx) == N_REQ - 1) ? 3'd0 : g_idx + 3'd1;
        g_valid  = |(req_valid & grant_q);
        g_last   = |(req_last & grant_q);
        g_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                g_data = req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Gating on tx_busy keeps a new byte from landing while the core still holds the last one.
    assign req_ready = (state_q == ST_SEND && !tx_busy) ? (req_valid & grant_q) : '0;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        din_d       = din_q;
        last_d      = last_q;
        gap_d       = gap_q;
        dat_en_d    = 1'b0;
        pkt_done_d  = 1'b0;
        gap_abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gap_d = '0;
                if (|req_valid) begin
                    grant_d = win;
                    // Header byte staged at grant time; a payload handshake overwrites it.
                    din_d   = TAG_BASE + 8'(onehot_idx(8'(win)));
`ifdef UART_TX_ARB_TAG_EN
                    state_d = ST_TAG;
`else
                    state_d = ST_SEND;
`endif
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            ST_TAG: begin
                if (!tx_busy) begin
                    last_d   = 1'b0;
                    dat_en_d = 1'b1;
                    state_d  = ST_START;
                end
            end
`endif
            ST_SEND: begin
                if (|req_ready) begin
                    din_d    = g_data;
                    last_d   = g_last;
                    dat_en_d = 1'b1;
                    state_d  = ST_START;
                end else if (!g_valid) begin
                    if (gap_q == GAP_LIM) begin
                        gap_abort_d = 1'b1;
                        grant_d     = '0;
                        ptr_d       = ptr_next;
                        state_d     = ST_IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (last_q) begin
                        pkt_done_d = 1'b1;
                        grant_d    = '0;
                        ptr_d      = ptr_next;
                        state_d    = ST_IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= 3'd0;
            din_q       <= '0;
            dat_en_q    <= 1'b0;
            last_q      <= 1'b0;
            gap_q       <= '0;
            pkt_done_q  <= 1'b0;
            gap_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            din_q       <= din_d;
            dat_en_q    <= dat_en_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            pkt_done_q  <= pkt_done_d;
            gap_abort_q <= gap_abort_d;
        end
    end

    assign grant     = grant_q;
    assign tx_dat_en = dat_en_q;
    assign tx_din    = din_q;
    assign pkt_done  = pkt_done_q;
    assign gap_abort = gap_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART core model;
// expected header bytes are added when UART_TX_ARB_TAG_EN is defined.
module tb_uart_tx_arbiter;

    localparam int         N        = 4;
    localparam int         GAP      = 16;
    localparam int         FRAME    = 12;
    localparam logic [7:0] TAG_BASE = 8'hA0;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid;
    logic [8*N-1:0]      req_data;
    logic [N-1:0]        req_last;
    logic [N-1:0]        req_ready;
    logic                tx_dat_en;
    logic [7:0]          tx_din;
    logic                tx_busy;
    logic                tx_done;
    logic [N-1:0]        grant;
    logic                pkt_done;
    logic                gap_abort;

    int checks = 0;
    int errors = 0;
    int pkt_cnt = 0;
    int abort_cnt = 0;

    logic [8:0]  pend [N][$];   // {last, data} per requester
    logic [11:0] exp_q [$];     // {owner, byte} in expected send order

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ    (N),
        .GAP_CYC  (GAP),
        .TAG_BASE (TAG_BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_dat_en (tx_dat_en),
        .tx_din    (tx_din),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .grant     (grant),
        .pkt_done  (pkt_done),
        .gap_abort (gap_abort)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait timed out, expected event never seen", name);
    endtask

    task automatic exp_head(input int i);
`ifdef UART_TX_ARB_TAG_EN
        exp_q.push_back({4'(i), TAG_BASE + 8'(i)});
`else
        if (i < 0) $display("bad requester %0d", i);
`endif
    endtask

    task automatic exp_byte(input int i, input logic [7:0] d);
        exp_q.push_back({4'(i), d});
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input logic last);
        pend[i].push_back({last, d});
    endtask

    function automatic bit pend_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_grant(input logic [N-1:0] g, input string name);
        int n;
        n = 0;
        while (grant !== g && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (grant !== g) timed_out(name);
    endtask

    task automatic wait_byte(input logic [7:0] d, input string name);
        int n;
        n = 0;
        while (!(tx_dat_en === 1'b1 && tx_din === d) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(tx_dat_en === 1'b1 && tx_din === d)) timed_out(name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(pend_empty() && req_valid == '0 && grant == '0 && !tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timed_out(name);
        repeat (2) @(negedge clk);
    endtask

    // Async reset asserted mid-cycle; outputs must be clear by the next sample.
    task automatic apply_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < N; i++) pend[i].delete();
        @(negedge clk);
        chk({name, "_grant"},     32'(grant),     0);
        chk({name, "_req_ready"}, 32'(req_ready), 0);
        chk({name, "_dat_en"},    32'(tx_dat_en), 0);
        chk({name, "_din"},       32'(tx_din),    0);
        chk({name, "_pkt_done"},  32'(pkt_done),  0);
        chk({name, "_gap_abort"}, 32'(gap_abort), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Requester drivers: hold each byte until it is consumed, then present the next.
    initial begin
        logic [N-1:0] hs;
        logic [8:0]   w;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    req_valid[i] = 1'b0;
                end else begin
                    if (hs[i]) req_valid[i] = 1'b0;
                    if (!req_valid[i] && pend[i].size() > 0) begin
                        w = pend[i].pop_front();
                        req_valid[i]        = 1'b1;
                        req_data[8*i +: 8]  = w[7:0];
                        req_last[i]         = w[8];
                    end
                end
            end
        end
    end

    // UART core model: busy for FRAME cycles, done pulse before busy drops.
    initial begin
        int   cnt;
        logic en_s;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        cnt     = 0;
        forever begin
            @(negedge clk);
            en_s = tx_dat_en;
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!rst_n) begin
                tx_busy = 1'b0;
                cnt     = 0;
            end else if (en_s) begin
                tx_busy = 1'b1;
                cnt     = FRAME;
            end else if (tx_busy) begin
                cnt--;
                if (cnt == 4) tx_done = 1'b1;
                if (cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    // Monitor: every byte handed to the core is checked against the scoreboard.
    initial begin
        logic [11:0] e;
        logic        prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_dat_en) begin
                    chk("dat_en_while_busy", 32'(tx_busy), 0);
                    chk("dat_en_pulse_width", 32'(prev_en), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h from grant %0h, expected none", tx_din, grant);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte_owner", 32'(grant), 32'(1) << e[11:8]);
                        chk("byte_data", 32'(tx_din), 32'(e[7:0]));
                    end
                end
                if (|req_ready) chk("ready_within_grant", 32'(req_ready & ~grant), 0);
                if (pkt_done) pkt_cnt++;
                if (gap_abort) abort_cnt++;
            end
            prev_en = tx_dat_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        apply_reset("reset_initial");

        // Single requester, three-byte packet; also measures start-up latency.
        exp_head(0);
        exp_byte(0, 8'h11); exp_byte(0, 8'h22); exp_byte(0, 8'h33);
        push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
        n = 0;
        while (!req_valid[0] && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (grant !== 4'b0001 && n < 50) begin @(negedge clk); n++; end
        chk("grant_latency", 32'(n), 1);
        while (tx_dat_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("dat_en_latency", 32'(n), 2);
        wait_idle("idle_after_t1");
        chk("pkt_done_t1", 32'(pkt_cnt), 1);

        // All four requesters at once with pointer at 0: order 0,1,2,3,0.
        apply_reset("reset_t2");
        exp_head(0); exp_byte(0, 8'h40);
        exp_head(1); exp_byte(1, 8'h50);
        exp_head(2); exp_byte(2, 8'h60);
        exp_head(3); exp_byte(3, 8'h70);
        exp_head(0); exp_byte(0, 8'h41);
        push_byte(0, 8'h40, 1'b1); push_byte(0, 8'h41, 1'b1);
        push_byte(1, 8'h50, 1'b1);
        push_byte(2, 8'h60, 1'b1);
        push_byte(3, 8'h70, 1'b1);
        wait_idle("idle_after_t2");
        chk("pkt_done_t2", 32'(pkt_cnt), 6);

        // Request arriving mid-packet waits for the current owner to finish.
        exp_head(1);
        exp_byte(1, 8'h81); exp_byte(1, 8'h82); exp_byte(1, 8'h83);
        exp_head(2); exp_byte(2, 8'h90);
        push_byte(1, 8'h81, 1'b0); push_byte(1, 8'h82, 1'b0); push_byte(1, 8'h83, 1'b1);
        wait_grant(4'b0010, "grant_req1_t3");
        push_byte(2, 8'h90, 1'b1);
        wait_idle("idle_after_t3");
        chk("pkt_done_t3", 32'(pkt_cnt), 8);

        // Owner stalls after a non-last byte: lock dropped after GAP idle cycles.
        exp_head(0); exp_byte(0, 8'h55);
        exp_head(1); exp_byte(1, 8'hA1);
        push_byte(0, 8'h55, 1'b0);
        wait_grant(4'b0001, "grant_req0_t4");
        push_byte(1, 8'hA1, 1'b1);
        wait_byte(8'h55, "byte55_t4");
        n = 0;
        while (tx_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (tx_done !== 1'b1) timed_out("done55_t4");
        n = 0;
        while (gap_abort !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("gap_abort_delay", 32'(n), 32'(GAP + 1));
        wait_idle("idle_after_t4");
        chk("gap_abort_count", 32'(abort_cnt), 1);
        chk("pkt_done_t4", 32'(pkt_cnt), 9);

        // Reset while a byte is in flight, then a clean restart.
        exp_head(3); exp_byte(3, 8'hC3);
        push_byte(3, 8'hC3, 1'b1);
        wait_byte(8'hC3, "byteC3_t5");
        repeat (3) @(negedge clk);
        chk("pre_reset_grant", 32'(grant), 32'h8);
        apply_reset("reset_mid_byte");
        exp_head(2); exp_byte(2, 8'hD2);
        push_byte(2, 8'hD2, 1'b1);
        wait_idle("idle_after_t5");
        chk("pkt_done_t5", 32'(pkt_cnt), 10);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("gap_abort_final", 32'(abort_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
